timer_core: RTL and testbench
=============================

TIMER_CORE -- requirements
Module: timer_core

Interface
REQ-001 Parameter CNT_BW_p, default 32: counter, load and compare width.
REQ-002 clk  in  1  single clock; all state on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_cnt0_en, i_cnt0_reload, i_cnt0_count_up  in  1 each  counter 0 enable, auto-reload, direction (1=up).
REQ-005 i_cnt0_load_value, i_cnt0_compare_value  in  CNT_BW_p each  counter 0 start and terminal values.
REQ-006 i_cnt1_en, i_cnt1_reload, i_cnt1_count_up  in  1 each  counter 1 equivalents.
REQ-007 i_cnt1_src  in  1  counter 1 tick source: 0 = every clk, 1 = counter 0 hit event.
REQ-008 i_cnt1_load_value, i_cnt1_compare_value  in  CNT_BW_p each  counter 1 start and terminal values.
REQ-009 i_irq_clr  in  2  write-one-to-clear for o_irq, bit N = counter N.
REQ-010 o_cnt0_value, o_cnt1_value  out  CNT_BW_p each  current count.
REQ-011 o_cnt0_match, o_cnt1_match  out  1 each  one-cycle hit pulse.
REQ-012 o_cnt0_running, o_cnt1_running  out  1 each  high in state RUN.
REQ-013 o_irq  out  2  sticky hit flags, bit N = counter N.

Function
REQ-014 Each counter SHALL run its own FSM with states IDLE, RUN and HALT.
REQ-015 Enable edges SHALL be detected from a registered copy of i_cntN_en.
REQ-016 Rising enable edge, any state: count <= load_value, state <= RUN, no tick evaluated that cycle.
REQ-017 i_cntN_en low, any state: state <= IDLE, count holds its value.
REQ-018 Tick in RUN, count != compare: count +1 if count_up, else -1, wrapping modulo 2^CNT_BW_p.
REQ-019 Tick in RUN, count == compare (hit): reload=1 gives count <= load_value, stay RUN; reload=0 gives count holds, state <= HALT.
REQ-020 HALT SHALL be left only via enable low (to IDLE) or reset; count holds in HALT.
REQ-021 Counter 0 SHALL tick every clk in RUN.
REQ-022 Counter 1 ticks every clk when src=0; when src=1 only in the cycle counter 0 detects a hit, with both counters updating on the same edge.
REQ-023 o_cntN_match SHALL be the registered hit: high exactly one cycle, the cycle after the hit edge.
REQ-024 o_irq[N] SHALL be set on a hit and cleared by i_irq_clr[N]=1; set wins on the same cycle.
REQ-025 Load and compare changes in RUN SHALL take effect at the next hit comparison or reload only; no restart.
REQ-026 load_value == compare: the first tick after start SHALL produce a hit.
REQ-027 Hit and enable-low in the same cycle: enable-low wins, no match pulse, no irq.

Reset
REQ-028 rst_n low SHALL immediately force: both states IDLE, counts 0, match 0, running 0, o_irq 0, enable history 0.
REQ-029 Reset deassertion with i_cntN_en already high SHALL count as a rising edge and load load_value on the first clk.
REQ-030 Reset mid-count SHALL discard all progress; no match or irq pulse is generated by reset.

Verification
REQ-031 cnt0 up, reload=1, load 0, compare 3 -> value 0,1,2,3,0,1...; o_cnt0_match every 4th cycle; running=1.
REQ-032 cnt0 down, reload=0, load 5, compare 2 -> 5,4,3,2 then holds 2; single match; running=0 (HALT); o_irq[0]=1 until i_irq_clr=01.
REQ-033 cnt0 up, load 0xFFFFFFFE, compare 1 -> 0xFFFFFFFE, 0xFFFFFFFF, 0, 1, match pulse.
REQ-034 Cascade: cnt0 load 0, compare 1, reload; cnt1 src=1, load 0, compare 2, reload -> cnt1 steps every 2 cycles; o_cnt1_match every 6 cycles.
REQ-035 Enable and irq stimulus:
- cnt0 enable dropped at value 7 -> holds 7, IDLE.
- Re-enable -> reloads load_value.
- o_irq set and i_irq_clr in the same cycle -> o_irq stays 1.
REQ-036 rst_n asserted asynchronously mid-RUN -> all outputs 0 before the next clk edge; restart after release per REQ-029.

Source files
------------

// File: rtl/timer_core.sv
// Dual programmable timer core.
// Two up/down counters share one clock. Each has its own IDLE/RUN/HALT
// state machine, a one-cycle registered match pulse and a sticky irq flag.
// Counter 1 can be cascaded so that it only advances on counter 0 hits.

module timer_chan #(
  parameter int CNT_BW_p = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                reload_i,
  input  logic                count_up_i,
  input  logic                tick_i,
  input  logic [CNT_BW_p-1:0] load_value_i,
  input  logic [CNT_BW_p-1:0] compare_value_i,
  output logic [CNT_BW_p-1:0] value_o,
  output logic                match_o,
  output logic                running_o,
  output logic                hit_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [CNT_BW_p-1:0] ONE_C = {{(CNT_BW_p-1){1'b0}}, 1'b1};

  logic                en_q;
  logic [1:0]          state_q, state_d;
  logic [CNT_BW_p-1:0] count_q, count_d;
  logic                match_q;
  logic                rise_s;
  logic                hit_s;

  // Next-state and next-count decode; enable-low beats every other event.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hit_s   = 1'b0;
    rise_s  = en_i & ~en_q;
    if (!en_i) begin
      // Disable parks the counter but keeps its value visible.
      state_d = ST_IDLE;
    end else if (rise_s) begin
      // A fresh start loads and skips tick evaluation for this cycle.
      count_d = load_value_i;
      state_d = ST_RUN;
    end else if ((state_q == ST_RUN) && tick_i) begin
      if (count_q == compare_value_i) begin
        hit_s = 1'b1;
        if (reload_i) begin
          count_d = load_value_i;
        end else begin
          state_d = ST_HALT;
        end
      end else if (count_up_i) begin
        count_d = count_q + ONE_C;
      end else begin
        count_d = count_q - ONE_C;
      end
    end else begin
      // IDLE, HALT or no tick: everything holds.
      state_d = state_q;
    end
  end

  // State, count, enable history and match pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      state_q <= ST_IDLE;
      count_q <= {CNT_BW_p{1'b0}};
      match_q <= 1'b0;
    end else begin
      en_q    <= en_i;
      state_q <= state_d;
      count_q <= count_d;
      match_q <= hit_s;
    end
  end

  assign value_o   = count_q;
  assign match_o   = match_q;
  assign running_o = (state_q == ST_RUN);
  assign hit_o     = hit_s;

endmodule

module timer_core #(
  parameter int CNT_BW_p = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cnt0_en,
  input  logic                i_cnt0_reload,
  input  logic                i_cnt0_count_up,
  input  logic [CNT_BW_p-1:0] i_cnt0_load_value,
  input  logic [CNT_BW_p-1:0] i_cnt0_compare_value,
  input  logic                i_cnt1_en,
  input  logic                i_cnt1_reload,
  input  logic                i_cnt1_count_up,
  input  logic                i_cnt1_src,
  input  logic [CNT_BW_p-1:0] i_cnt1_load_value,
  input  logic [CNT_BW_p-1:0] i_cnt1_compare_value,
  input  logic [1:0]          i_irq_clr,
  output logic [CNT_BW_p-1:0] o_cnt0_value,
  output logic [CNT_BW_p-1:0] o_cnt1_value,
  output logic                o_cnt0_match,
  output logic                o_cnt1_match,
  output logic                o_cnt0_running,
  output logic                o_cnt1_running,
  output logic [1:0]          o_irq
);

  logic       hit0_s, hit1_s;
  logic       tick1_s;
  logic [1:0] irq_q, irq_d;

  // Counter 1 either free-runs or steps on counter 0 hits in the same edge.
  always_comb begin
    if (i_cnt1_src) begin
      tick1_s = hit0_s;
    end else begin
      tick1_s = 1'b1;
    end
  end

  timer_chan #(.CNT_BW_p(CNT_BW_p)) u_cnt0 (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_i            (i_cnt0_en),
    .reload_i        (i_cnt0_reload),
    .count_up_i      (i_cnt0_count_up),
    .tick_i          (1'b1),
    .load_value_i    (i_cnt0_load_value),
    .compare_value_i (i_cnt0_compare_value),
    .value_o         (o_cnt0_value),
    .match_o         (o_cnt0_match),
    .running_o       (o_cnt0_running),
    .hit_o           (hit0_s)
  );

  timer_chan #(.CNT_BW_p(CNT_BW_p)) u_cnt1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_i            (i_cnt1_en),
    .reload_i        (i_cnt1_reload),
    .count_up_i      (i_cnt1_count_up),
    .tick_i          (tick1_s),
    .load_value_i    (i_cnt1_load_value),
    .compare_value_i (i_cnt1_compare_value),
    .value_o         (o_cnt1_value),
    .match_o         (o_cnt1_match),
    .running_o       (o_cnt1_running),
    .hit_o           (hit1_s)
  );

  // Sticky irq flags: a new hit outranks a simultaneous clear.
  always_comb begin
    irq_d = (irq_q & ~i_irq_clr) | {hit1_s, hit0_s};
  end

  // Irq flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 2'b00;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign o_irq = irq_q;

endmodule

// File: tb/tb_timer_core.sv
// Directed self-checking bench for timer_core.
module tb_timer_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cnt0_en, i_cnt0_reload, i_cnt0_count_up;
  logic [31:0] i_cnt0_load_value, i_cnt0_compare_value;
  logic        i_cnt1_en, i_cnt1_reload, i_cnt1_count_up, i_cnt1_src;
  logic [31:0] i_cnt1_load_value, i_cnt1_compare_value;
  logic [1:0]  i_irq_clr;
  logic [31:0] o_cnt0_value, o_cnt1_value;
  logic        o_cnt0_match, o_cnt1_match, o_cnt0_running, o_cnt1_running;
  logic [1:0]  o_irq;

  int vec_cnt = 0;
  int err_cnt = 0;

  timer_core #(.CNT_BW_p(32)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_cnt0_en            (i_cnt0_en),
    .i_cnt0_reload        (i_cnt0_reload),
    .i_cnt0_count_up      (i_cnt0_count_up),
    .i_cnt0_load_value    (i_cnt0_load_value),
    .i_cnt0_compare_value (i_cnt0_compare_value),
    .i_cnt1_en            (i_cnt1_en),
    .i_cnt1_reload        (i_cnt1_reload),
    .i_cnt1_count_up      (i_cnt1_count_up),
    .i_cnt1_src           (i_cnt1_src),
    .i_cnt1_load_value    (i_cnt1_load_value),
    .i_cnt1_compare_value (i_cnt1_compare_value),
    .i_irq_clr            (i_irq_clr),
    .o_cnt0_value         (o_cnt0_value),
    .o_cnt1_value         (o_cnt1_value),
    .o_cnt0_match         (o_cnt0_match),
    .o_cnt1_match         (o_cnt1_match),
    .o_cnt0_running       (o_cnt0_running),
    .o_cnt1_running       (o_cnt1_running),
    .o_irq                (o_irq)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Park both counters and wipe irq flags between scenarios.
  task automatic go_idle();
    i_cnt0_en = 1'b0; i_cnt1_en = 1'b0; i_cnt1_src = 1'b0;
    i_irq_clr = 2'b11;
    tick();
    i_irq_clr = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_cnt0_en = 1'b0; i_cnt0_reload = 1'b0; i_cnt0_count_up = 1'b1;
    i_cnt0_load_value = 32'd0; i_cnt0_compare_value = 32'd0;
    i_cnt1_en = 1'b0; i_cnt1_reload = 1'b0; i_cnt1_count_up = 1'b1; i_cnt1_src = 1'b0;
    i_cnt1_load_value = 32'd0; i_cnt1_compare_value = 32'd0;
    i_irq_clr = 2'b00;
    #23;
    vec_cnt++;
    if ({o_cnt0_value, o_cnt1_value} !== 64'd0) begin
      $display("FAIL reset_values: got %0h/%0h expected 0/0", o_cnt0_value, o_cnt1_value); err_cnt++;
    end
    vec_cnt++;
    if ({o_cnt0_match, o_cnt1_match, o_cnt0_running, o_cnt1_running, o_irq} !== 6'b0) begin
      $display("FAIL reset_flags: got %b%b%b%b%b expected 000000", o_cnt0_match, o_cnt1_match,
               o_cnt0_running, o_cnt1_running, o_irq); err_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vec_cnt++;
    if (o_cnt0_running !== 1'b0 || o_cnt0_value !== 32'd0) begin
      $display("FAIL reset_idle: got run=%b val=%0h expected run=0 val=0", o_cnt0_running, o_cnt0_value); err_cnt++;
    end
  endtask

  task automatic test_up_reload();
    logic [31:0] exp_v;
    logic        exp_m;
    i_cnt0_load_value = 32'd0; i_cnt0_compare_value = 32'd3;
    i_cnt0_count_up = 1'b1; i_cnt0_reload = 1'b1; i_cnt0_en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_v = 32'((k - 1) % 4);
      exp_m = (k >= 5) && (((k - 1) % 4) == 0);
      vec_cnt++;
      if (o_cnt0_value !== exp_v || o_cnt0_match !== exp_m || o_cnt0_running !== 1'b1) begin
        $display("FAIL up_reload edge %0d: got val=%0h m=%b run=%b expected val=%0h m=%b run=1",
                 k, o_cnt0_value, o_cnt0_match, o_cnt0_running, exp_v, exp_m); err_cnt++;
      end
    end
    vec_cnt++;
    if (o_irq !== 2'b01) begin
      $display("FAIL up_reload_irq: got %b expected 01", o_irq); err_cnt++;
    end
    go_idle();
  endtask

  task automatic test_down_halt();
    logic [31:0] exp_tab [0:5];
    logic [5:0]  exp_m = 6'b010000;
    logic [5:0]  exp_r = 6'b001111;
    exp_tab[0] = 32'd5; exp_tab[1] = 32'd4; exp_tab[2] = 32'd3;
    exp_tab[3] = 32'd2; exp_tab[4] = 32'd2; exp_tab[5] = 32'd2;
    i_cnt0_load_value = 32'd5; i_cnt0_compare_value = 32'd2;
    i_cnt0_count_up = 1'b0; i_cnt0_reload = 1'b0; i_cnt0_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      vec_cnt++;
      if (o_cnt0_value !== exp_tab[k] || o_cnt0_match !== exp_m[k] || o_cnt0_running !== exp_r[k]) begin
        $display("FAIL down_halt edge %0d: got val=%0h m=%b run=%b expected val=%0h m=%b run=%b",
                 k + 1, o_cnt0_value, o_cnt0_match, o_cnt0_running, exp_tab[k], exp_m[k], exp_r[k]); err_cnt++;
      end
    end
    vec_cnt++;
    if (o_irq !== 2'b01) begin
      $display("FAIL down_halt_irq_sticky: got %b expected 01", o_irq); err_cnt++;
    end
    i_irq_clr = 2'b01;
    tick();
    i_irq_clr = 2'b00;
    vec_cnt++;
    if (o_irq !== 2'b00 || o_cnt0_value !== 32'd2) begin
      $display("FAIL down_halt_clr: got irq=%b val=%0h expected irq=00 val=2", o_irq, o_cnt0_value); err_cnt++;
    end
    go_idle();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_tab [0:4];
    exp_tab[0] = 32'hFFFF_FFFE; exp_tab[1] = 32'hFFFF_FFFF; exp_tab[2] = 32'd0;
    exp_tab[3] = 32'd1; exp_tab[4] = 32'd1;
    i_cnt0_load_value = 32'hFFFF_FFFE; i_cnt0_compare_value = 32'd1;
    i_cnt0_count_up = 1'b1; i_cnt0_reload = 1'b0; i_cnt0_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      vec_cnt++;
      if (o_cnt0_value !== exp_tab[k] || o_cnt0_match !== (k == 4)) begin
        $display("FAIL wrap edge %0d: got val=%0h m=%b expected val=%0h m=%b",
                 k + 1, o_cnt0_value, o_cnt0_match, exp_tab[k], (k == 4)); err_cnt++;
      end
    end
    go_idle();
  endtask

  task automatic test_cascade();
    logic [31:0] e0, e1;
    logic        m0, m1;
    i_cnt0_load_value = 32'd0; i_cnt0_compare_value = 32'd1;
    i_cnt0_count_up = 1'b1; i_cnt0_reload = 1'b1;
    i_cnt1_load_value = 32'd0; i_cnt1_compare_value = 32'd2;
    i_cnt1_count_up = 1'b1; i_cnt1_reload = 1'b1; i_cnt1_src = 1'b1;
    i_cnt0_en = 1'b1; i_cnt1_en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      e0 = 32'((k - 1) % 2);
      e1 = 32'(((k - 1) / 2) % 3);
      m0 = (k >= 3) && (((k - 1) % 2) == 0);
      m1 = (k >= 7) && (((k - 1) % 6) == 0);
      vec_cnt++;
      if (o_cnt0_value !== e0 || o_cnt1_value !== e1 || o_cnt0_match !== m0 || o_cnt1_match !== m1) begin
        $display("FAIL cascade edge %0d: got c0=%0h c1=%0h m0=%b m1=%b expected c0=%0h c1=%0h m0=%b m1=%b",
                 k, o_cnt0_value, o_cnt1_value, o_cnt0_match, o_cnt1_match, e0, e1, m0, m1); err_cnt++;
      end
    end
    go_idle();
  endtask

  task automatic test_enable_irq();
    i_cnt0_load_value = 32'd0; i_cnt0_compare_value = 32'd100;
    i_cnt0_count_up = 1'b1; i_cnt0_reload = 1'b0; i_cnt0_en = 1'b1;
    repeat (8) tick();
    i_cnt0_en = 1'b0;
    tick(); tick();
    vec_cnt++;
    if (o_cnt0_value !== 32'd7 || o_cnt0_running !== 1'b0) begin
      $display("FAIL disable_hold: got val=%0h run=%b expected val=7 run=0", o_cnt0_value, o_cnt0_running); err_cnt++;
    end
    i_cnt0_load_value = 32'd20; i_cnt0_en = 1'b1;
    tick();
    vec_cnt++;
    if (o_cnt0_value !== 32'd20 || o_cnt0_running !== 1'b1) begin
      $display("FAIL reenable_load: got val=%0h run=%b expected val=14 run=1", o_cnt0_value, o_cnt0_running); err_cnt++;
    end
    i_cnt0_compare_value = 32'd22;
    tick(); tick();
    i_irq_clr = 2'b01;
    tick();
    vec_cnt++;
    if (o_irq !== 2'b01 || o_cnt0_match !== 1'b1 || o_cnt0_value !== 32'd22) begin
      $display("FAIL set_beats_clr: got irq=%b m=%b val=%0h expected irq=01 m=1 val=16",
               o_irq, o_cnt0_match, o_cnt0_value); err_cnt++;
    end
    tick();
    i_irq_clr = 2'b00;
    vec_cnt++;
    if (o_irq !== 2'b00) begin
      $display("FAIL clr_after_set: got %b expected 00", o_irq); err_cnt++;
    end
    go_idle();
    // Counter 1: disable on the hit cycle suppresses match and irq.
    i_cnt1_load_value = 32'd0; i_cnt1_compare_value = 32'd2;
    i_cnt1_count_up = 1'b1; i_cnt1_reload = 1'b1; i_cnt1_src = 1'b0; i_cnt1_en = 1'b1;
    repeat (3) tick();
    i_cnt1_en = 1'b0;
    tick();
    vec_cnt++;
    if (o_cnt1_value !== 32'd2 || o_cnt1_match !== 1'b0 || o_irq !== 2'b00 || o_cnt1_running !== 1'b0) begin
      $display("FAIL hit_vs_disable: got val=%0h m=%b irq=%b run=%b expected val=2 m=0 irq=00 run=0",
               o_cnt1_value, o_cnt1_match, o_irq, o_cnt1_running); err_cnt++;
    end
    // load == compare hits on the first tick after start.
    i_cnt1_load_value = 32'd5; i_cnt1_compare_value = 32'd5; i_cnt1_reload = 1'b0; i_cnt1_en = 1'b1;
    tick(); tick();
    vec_cnt++;
    if (o_cnt1_match !== 1'b1 || o_irq !== 2'b10 || o_cnt1_value !== 32'd5) begin
      $display("FAIL load_eq_cmp: got m=%b irq=%b val=%0h expected m=1 irq=10 val=5",
               o_cnt1_match, o_irq, o_cnt1_value); err_cnt++;
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    i_cnt0_load_value = 32'd3; i_cnt0_compare_value = 32'd100;
    i_cnt0_count_up = 1'b1; i_cnt0_reload = 1'b0; i_cnt0_en = 1'b1;
    i_cnt1_load_value = 32'd0; i_cnt1_compare_value = 32'd0;
    i_cnt1_reload = 1'b1; i_cnt1_src = 1'b0; i_cnt1_en = 1'b1;
    repeat (4) tick();
    vec_cnt++;
    if (o_cnt0_value !== 32'd6 || o_irq !== 2'b10) begin
      $display("FAIL pre_reset: got val=%0h irq=%b expected val=6 irq=10", o_cnt0_value, o_irq); err_cnt++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({o_cnt0_value, o_cnt1_value, o_cnt0_match, o_cnt1_match, o_cnt0_running, o_cnt1_running, o_irq} !== 70'd0) begin
      $display("FAIL async_reset: got c0=%0h c1=%0h m=%b%b run=%b%b irq=%b expected all 0", o_cnt0_value,
               o_cnt1_value, o_cnt0_match, o_cnt1_match, o_cnt0_running, o_cnt1_running, o_irq); err_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vec_cnt++;
    if (o_cnt0_value !== 32'd3 || o_cnt0_running !== 1'b1 || o_cnt1_running !== 1'b1 ||
        o_cnt1_match !== 1'b0 || o_irq !== 2'b00) begin
      $display("FAIL restart: got val=%0h run=%b%b m1=%b irq=%b expected val=3 run=11 m1=0 irq=00",
               o_cnt0_value, o_cnt0_running, o_cnt1_running, o_cnt1_match, o_irq); err_cnt++;
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_up_reload();
    test_down_halt();
    test_wrap();
    test_cascade();
    test_enable_irq();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
